// File: rtl/dmem_pkg.sv
// Shared types for the data-memory port B arbiter.
// Access sizes, lock timeout and the per-master request bundle.
package dmem_pkg;

   localparam int unsigned DMEM_AW = 12;
   localparam int unsigned LOCK_TIMEOUT = 16;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } mem_size_e;

   typedef struct packed {
      logic             we;
      mem_size_e        size;
      logic [DMEM_AW-1:0] addr;
      logic [31:0]      wdata;
   } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with per-master mask.
// On a conflict the master that did not win last time is chosen.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);

   logic       last;
   logic [1:0] elig;

   assign elig = req & ~mask;

   always_comb begin
      gnt = 2'b00;
      unique case (1'b1)
         (elig == 2'b11): gnt = last ? 2'b01 : 2'b10;
         (elig == 2'b01): gnt = 2'b01;
         (elig == 2'b10): gnt = 2'b10;
         default:         gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= 1'b1;
      end else if (|gnt) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates RAM port B between the LSU (m0) and debug DMA (m1).
// m1 may lock the port for a burst; loads return one cycle after grant.
module dmem_port_arbiter
   import dmem_pkg::*;
#(
   parameter int DMEM_ADDR_WIDTH = 12
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_m0_req,
   input  logic                       i_m0_we,
   input  logic [1:0]                 i_m0_size,
   input  logic [DMEM_ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [31:0]                i_m0_wdata,
   output logic                       o_m0_gnt,
   output logic                       o_m0_rvalid,
   output logic [31:0]                o_m0_rdata,
   input  logic                       i_m1_req,
   input  logic                       i_m1_we,
   input  logic [1:0]                 i_m1_size,
   input  logic [DMEM_ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [31:0]                i_m1_wdata,
   output logic                       o_m1_gnt,
   output logic                       o_m1_rvalid,
   output logic [31:0]                o_m1_rdata,
   input  logic                       i_m1_lock,
   output logic [DMEM_ADDR_WIDTH-1:0] o_addr_b,
   output logic                       o_we_b,
   output logic [1:0]                 o_size_b,
   output logic [31:0]                o_din_b,
   input  logic [31:0]                i_dout_b,
   output logic                       o_busy
);

   typedef enum logic {UNLOCKED, LOCKED} lock_e;

   lock_e                      state;
   lock_e                      state_nxt;
   logic [3:0]                 idle_cnt;
   logic [1:0]                 req;
   logic [1:0]                 mask;
   logic [1:0]                 gnt;
   logic                       any;
   mem_req_t                   m0;
   mem_req_t                   m1;
   mem_req_t                   win;
   logic                       resp_valid;
   logic                       resp_owner;
   logic [DMEM_ADDR_WIDTH-1:0] held_addr;
   logic [1:0]                 held_size;
   logic [31:0]                held_din;

   assign m0 = '{we: i_m0_we, size: mem_size_e'(i_m0_size),
                 addr: DMEM_AW'(i_m0_addr), wdata: i_m0_wdata};
   assign m1 = '{we: i_m1_we, size: mem_size_e'(i_m1_size),
                 addr: DMEM_AW'(i_m1_addr), wdata: i_m1_wdata};

   // No grant may escape while reset is asserted
   assign req  = {i_m1_req, i_m0_req} & {2{i_rst_n}};
   assign mask = {1'b0, state == LOCKED};

   rr_arb2 u_arb (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .req   (req),
      .mask  (mask),
      .gnt   (gnt)
   );

   assign win      = gnt[1] ? m1 : m0;
   assign any      = |gnt;
   assign o_m0_gnt = gnt[0];
   assign o_m1_gnt = gnt[1];

   assign o_we_b   = any & win.we;
   assign o_addr_b = any ? DMEM_ADDR_WIDTH'(win.addr) : held_addr;
   assign o_size_b = any ? win.size : held_size;
   assign o_din_b  = any ? win.wdata : held_din;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         held_addr  <= '0;
         held_size  <= '0;
         held_din   <= '0;
         resp_valid <= 1'b0;
         resp_owner <= 1'b0;
      end else begin
         if (any) begin
            held_addr <= DMEM_ADDR_WIDTH'(win.addr);
            held_size <= win.size;
            held_din  <= win.wdata;
         end
         resp_valid <= any & ~win.we;
         resp_owner <= gnt[1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= UNLOCKED;
         idle_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (i_m1_req) begin
            idle_cnt <= '0;
         end else if (idle_cnt != 4'hf) begin
            idle_cnt <= idle_cnt + 4'd1;
         end
      end
   end

   // Timeout fires on the idle cycle that carries the count to 15
   always_comb begin
      state_nxt = state;
      unique case (state)
         UNLOCKED: begin
            if (gnt[1] & i_m1_lock) state_nxt = LOCKED;
         end
         LOCKED: begin
            if (gnt[1] & ~i_m1_lock) begin
               state_nxt = UNLOCKED;
            end else if (~i_m1_req &&
                         idle_cnt >= 4'(LOCK_TIMEOUT - 2)) begin
               state_nxt = UNLOCKED;
            end
         end
         default: state_nxt = UNLOCKED;
      endcase
   end

   assign o_m0_rvalid = resp_valid & ~resp_owner;
   assign o_m1_rvalid = resp_valid & resp_owner;
   assign o_m0_rdata  = o_m0_rvalid ? i_dout_b : 32'h0;
   assign o_m1_rdata  = o_m1_rvalid ? i_dout_b : 32'h0;
   assign o_busy      = resp_valid | (state == LOCKED);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a byte-array RAM model
// that writes before it reads on each edge.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
   logic [1:0]  m0_size, m1_size;
   logic [11:0] m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [11:0] addr_b;
   logic        we_b, busy;
   logic [1:0]  size_b;
   logic [31:0] din_b, dout_b;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.DMEM_ADDR_WIDTH(12)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_size(m0_size),
      .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
      .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
      .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_size(m1_size),
      .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
      .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
      .i_m1_lock(m1_lock),
      .o_addr_b(addr_b), .o_we_b(we_b), .o_size_b(size_b),
      .o_din_b(din_b), .i_dout_b(dout_b), .o_busy(busy)
   );

   // RAM model
   logic [7:0] mem [4096];
   bit         init_done;

   task automatic wr(input logic [11:0] a, input logic [31:0] d,
                     input int nb);
      for (int k = 0; k < nb; k++) mem[12'(a + k)] = d[8*k +: 8];
   endtask

   always @(posedge clk) begin
      if (!init_done) begin
         wr(12'h010, 32'hDEADBEEF, 4);
         wr(12'h020, 32'h11111111, 4);
         wr(12'h024, 32'h22222222, 4);
         init_done = 1'b1;
      end
      if (we_b) wr(addr_b, din_b, size_b == 2'b00 ? 1 :
                                 size_b == 2'b01 ? 2 : 4);
      dout_b <= {mem[12'(addr_b + 3)], mem[12'(addr_b + 2)],
                 mem[12'(addr_b + 1)], mem[addr_b]};
   end

   typedef struct {
      logic r0, w0; logic [11:0] a0; logic [31:0] d0;
      logic r1, w1; logic [11:0] a1; logic [31:0] d1; logic lk;
      logic [81:0] exp;
   } vec_t;

   vec_t tbl [14];

   function automatic vec_t mk(
      input logic r0, w0, input logic [11:0] a0, input logic [31:0] d0,
      input logic r1, w1, input logic [11:0] a1, input logic [31:0] d1,
      input logic lk,
      input logic g0, g1, we, input logic [11:0] ab,
      input logic rv0, rv1, input logic [31:0] rd0, rd1, input logic bz);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
      v.exp = {g0, g1, we, ab, rv0, rv1, rd0, rd1, bz};
      return v;
   endfunction

   function automatic logic [81:0] act();
      return {m0_gnt, m1_gnt, we_b, addr_b, m0_rvalid, m1_rvalid,
              m0_rdata, m1_rdata, busy};
   endfunction

   task automatic chk(input string name, input logic [127:0] a,
                      input logic [127:0] e);
      n_vec++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, a, e);
      end
   endtask

   task automatic drive(input vec_t v);
      m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
      m1_lock = v.lk; m0_size = 2'b10; m1_size = 2'b10;
   endtask

   initial begin
      tbl[0]  = mk(1,0,12'h020,0, 1,0,12'h024,0,0,
                   1,0,0,12'h020, 0,0,0,0, 0);
      tbl[1]  = mk(1,0,12'h020,0, 1,0,12'h024,0,0,
                   0,1,0,12'h024, 1,0,32'h11111111,0, 1);
      tbl[2]  = mk(1,0,12'h020,0, 1,0,12'h024,0,0,
                   1,0,0,12'h020, 0,1,0,32'h22222222, 1);
      tbl[3]  = mk(1,0,12'h020,0, 1,0,12'h024,0,0,
                   0,1,0,12'h024, 1,0,32'h11111111,0, 1);
      tbl[4]  = mk(0,0,0,0, 0,0,0,0,0,
                   0,0,0,12'h024, 0,1,0,32'h22222222, 1);
      tbl[5]  = mk(1,0,12'h010,0, 0,0,0,0,0,
                   1,0,0,12'h010, 0,0,0,0, 0);
      tbl[6]  = mk(0,0,0,0, 1,1,12'h003,32'h12345678,0,
                   0,1,1,12'h003, 1,0,32'hDEADBEEF,0, 1);
      tbl[7]  = mk(1,0,12'h003,0, 0,0,0,0,0,
                   1,0,0,12'h003, 0,0,0,0, 0);
      tbl[8]  = mk(0,0,0,0, 0,0,0,0,0,
                   0,0,0,12'h003, 1,0,32'h12345678,0, 1);
      tbl[9]  = mk(0,0,0,0, 1,1,12'h040,32'hA1,1,
                   0,1,1,12'h040, 0,0,0,0, 0);
      tbl[10] = mk(1,1,12'h050,32'hB0, 1,1,12'h044,32'hA2,1,
                   0,1,1,12'h044, 0,0,0,0, 1);
      tbl[11] = mk(1,1,12'h050,32'hB0, 1,1,12'h048,32'hA3,0,
                   0,1,1,12'h048, 0,0,0,0, 1);
      tbl[12] = mk(1,1,12'h050,32'hB0, 0,0,0,0,0,
                   1,0,1,12'h050, 0,0,0,0, 0);
      tbl[13] = mk(0,0,0,0, 0,0,0,0,0,
                   0,0,0,12'h050, 0,0,0,0, 0);

      rst_n = 1'b0;
      drive(tbl[13]);
      m0_req = 1'b1; m1_req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt", 128'({m0_gnt, m1_gnt}), 128'(0));
      chk("reset_out", 128'({act(), size_b, din_b}), 128'(0));
      #2 rst_n = 1'b1;
      drive(tbl[13]);
      @(posedge clk); #1;

      for (int i = 0; i < 14; i++) begin
         drive(tbl[i]);
         @(negedge clk);
         chk($sformatf("vec%0d", i), 128'(act()), 128'(tbl[i].exp));
         @(posedge clk); #1;
      end

      // lock timeout
      drive(tbl[13]);
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 12'h070; m1_lock = 1'b1;
      @(negedge clk);
      chk("tmo_take", 128'({m0_gnt, m1_gnt}), 128'(2'b01));
      @(posedge clk); #1;
      m1_req = 1'b0; m1_lock = 1'b0;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 12'h060;
      m0_wdata = 32'hC0FFEE00;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         chk($sformatf("tmo_gnt%0d", k), 128'(m0_gnt), 128'(k == 16));
         if (k == 1 || k >= 15)
            chk($sformatf("tmo_busy%0d", k), 128'(busy), 128'(k != 16));
         @(posedge clk); #1;
      end

      // reset while a load response is pending
      m0_we = 1'b0; m0_addr = 12'h010;
      @(negedge clk);
      chk("rst_load_gnt", 128'(m0_gnt), 128'(1));
      @(posedge clk); #1;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 12'h024;
      chk("rst_pre_rv", 128'(m0_rvalid), 128'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_mid_out", 128'({act(), size_b, din_b}), 128'(0));
      @(negedge clk);
      chk("rst_hold", 128'({act(), size_b, din_b}), 128'(0));
      #2 rst_n = 1'b1;
      #1;
      chk("post_rst_gnt", 128'({m0_gnt, m1_gnt, m0_rvalid}),
          128'(3'b100));
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_rv", 128'({m1_gnt, m0_rvalid, m0_rdata}),
          128'({2'b11, 32'hDEADBEEF}));

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
